sp_bram_cmd_sequencer: RTL and testbench

//  Command-mailbox controller for the special-purpose BRAM (SP BRAM) shared with the PS host.

---
 rtl/sp_bram_cmd_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_sp_bram_cmd_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_bram_cmd_sequencer.sv
// Command-mailbox sequencer for the SP BRAM shared with the PS host: polls CMD,
// fetches the job descriptor, runs the systolic array and posts STATUS back.
module sp_bram_cmd_sequencer #(
   parameter int RD_LATENCY     = 2,
   parameter int POLL_INTERVAL  = 16,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] addr_sp_bram,
   output logic                  enable_sp_bram,
   output logic [3:0]            w_enable_sp_bram,
   output logic [31:0]           data_in_sp_bram,
   input  logic [31:0]           data_out_sp_bram,
   output logic                  array_start,
   input  logic                  array_done,
   output logic [31:0]           cfg_len,
   output logic [31:0]           cfg_act_base,
   output logic [31:0]           cfg_wgt_base,
   output logic [31:0]           cfg_out_base,
   output logic                  busy,
   output logic [5:0]            DEBUG_state
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_POLL_WAIT = 3'd1,
      ST_FETCH     = 3'd2,
      ST_LAUNCH    = 3'd3,
      ST_RUN       = 3'd4,
      ST_WR_STATUS = 3'd5,
      ST_CLR_CMD   = 3'd6
   } state_t;

   localparam logic [31:0]           POLL_LAST   = 32'(POLL_INTERVAL);
   localparam logic [7:0]            LAT_LAST    = 8'(RD_LATENCY - 1);
   localparam logic [7:0]            FETCH_LAST  = 8'(RD_LATENCY + 2);
   localparam logic [31:0]           TIMEOUT_W   = 32'(TIMEOUT_CYCLES);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CMD    = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LEN    = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(20);

   state_t      state_reg, state_next;
   logic [31:0] poll_cnt_reg, poll_cnt_next;
   logic [7:0]  step_cnt_reg, step_cnt_next;
   logic [31:0] run_cnt_reg, run_cnt_next;
   logic        done_reg, done_next;
   logic        timeout_reg, timeout_next;
   logic [31:0] run_cnt_inc;
   logic [7:0]  fetch_word;
   logic [23:0] status_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         poll_cnt_reg <= '0;
         step_cnt_reg <= '0;
         run_cnt_reg  <= '0;
         done_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         poll_cnt_reg <= poll_cnt_next;
         step_cnt_reg <= step_cnt_next;
         run_cnt_reg  <= run_cnt_next;
         done_reg     <= done_next;
         timeout_reg  <= timeout_next;
      end
   end

   // Descriptor word gi+1 was issued at FETCH step gi-1, so it lands at step gi+RD_LATENCY-1.
   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      logic [31:0] word_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            word_reg <= '0;
         else if (state_reg == ST_FETCH && step_cnt_reg == 8'(RD_LATENCY - 1 + gi))
            word_reg <= data_out_sp_bram;
      end
   end

   assign cfg_len      = g_cfg[0].word_reg;
   assign cfg_act_base = g_cfg[1].word_reg;
   assign cfg_wgt_base = g_cfg[2].word_reg;
   assign cfg_out_base = g_cfg[3].word_reg;

   assign busy        = !(state_reg == ST_IDLE || state_reg == ST_POLL_WAIT);
   assign DEBUG_state = {3'b000, state_reg};

   always_comb begin
      state_next       = state_reg;
      poll_cnt_next    = poll_cnt_reg;
      step_cnt_next    = step_cnt_reg;
      run_cnt_next     = run_cnt_reg;
      done_next        = done_reg;
      timeout_next     = timeout_reg;
      addr_sp_bram     = '0;
      enable_sp_bram   = 1'b0;
      w_enable_sp_bram = 4'h0;
      data_in_sp_bram  = '0;
      array_start      = 1'b0;
      run_cnt_inc      = run_cnt_reg + 32'd1;
      fetch_word       = step_cnt_reg + 8'd2;
      status_cnt       = (run_cnt_reg > 32'h00FF_FFFF) ? 24'hFF_FFFF : run_cnt_reg[23:0];

      case (state_reg)
         ST_IDLE: begin
            if (poll_cnt_reg >= POLL_LAST) begin
               enable_sp_bram = 1'b1;
               addr_sp_bram   = ADDR_CMD;
               poll_cnt_next  = '0;
               step_cnt_next  = '0;
               state_next     = ST_POLL_WAIT;
            end else begin
               poll_cnt_next = poll_cnt_reg + 32'd1;
            end
         end
         ST_POLL_WAIT: begin
            if (step_cnt_reg >= LAT_LAST) begin
               step_cnt_next = '0;
               // Word 1 is requested on the start-bit cycle so FETCH spans 4+RD_LATENCY-1 cycles.
               if (data_out_sp_bram[0]) begin
                  enable_sp_bram = 1'b1;
                  addr_sp_bram   = ADDR_LEN;
                  state_next     = ST_FETCH;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               step_cnt_next = step_cnt_reg + 8'd1;
            end
         end
         ST_FETCH: begin
            if (step_cnt_reg < 8'd3) begin
               enable_sp_bram = 1'b1;
               addr_sp_bram   = ADDR_WIDTH'({fetch_word, 2'b00});
            end
            if (step_cnt_reg >= FETCH_LAST) begin
               step_cnt_next = '0;
               run_cnt_next  = '0;
               if (cfg_len == 32'd0) begin
                  done_next    = 1'b1;
                  timeout_next = 1'b0;
                  state_next   = ST_WR_STATUS;
               end else begin
                  state_next = ST_LAUNCH;
               end
            end else begin
               step_cnt_next = step_cnt_reg + 8'd1;
            end
         end
         ST_LAUNCH: begin
            array_start  = 1'b1;
            run_cnt_next = '0;
            done_next    = 1'b0;
            timeout_next = 1'b0;
            state_next   = ST_RUN;
         end
         ST_RUN: begin
            run_cnt_next = run_cnt_inc;
            if (array_done) begin
               done_next  = 1'b1;
               state_next = ST_WR_STATUS;
            end else if (run_cnt_inc >= TIMEOUT_W) begin
               timeout_next = 1'b1;
               state_next   = ST_WR_STATUS;
            end
         end
         ST_WR_STATUS: begin
            enable_sp_bram   = 1'b1;
            w_enable_sp_bram = 4'hF;
            addr_sp_bram     = ADDR_STATUS;
            data_in_sp_bram  = {status_cnt, 6'b0, timeout_reg, done_reg};
            state_next       = ST_CLR_CMD;
         end
         ST_CLR_CMD: begin
            enable_sp_bram   = 1'b1;
            w_enable_sp_bram = 4'hF;
            addr_sp_bram     = ADDR_CMD;
            data_in_sp_bram  = '0;
            poll_cnt_next    = '0;
            state_next       = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sp_bram_cmd_sequencer.sv
// Bench for sp_bram_cmd_sequencer: 2-cycle BRAM model, descriptor table, random jobs
// against a job-level status model, idle polling and mid-run reset sequences.
module tb_sp_bram_cmd_sequencer;

   localparam int T   = 64;
   localparam int P   = 16;
   localparam int RDL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr;
   logic        enable;
   logic [3:0]  we;
   logic [31:0] din;
   logic [31:0] data_out = '0;
   logic        array_start;
   logic        array_done = 1'b0;
   logic [31:0] cfg_len, cfg_act, cfg_wgt, cfg_out;
   logic        busy;
   logic [5:0]  dbg_state;

   always #5 clk = ~clk;

   sp_bram_cmd_sequencer #(
      .RD_LATENCY(RDL), .POLL_INTERVAL(P), .TIMEOUT_CYCLES(T), .ADDR_WIDTH(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .addr_sp_bram(addr), .enable_sp_bram(enable), .w_enable_sp_bram(we),
      .data_in_sp_bram(din), .data_out_sp_bram(data_out),
      .array_start(array_start), .array_done(array_done),
      .cfg_len(cfg_len), .cfg_act_base(cfg_act), .cfg_wgt_base(cfg_wgt), .cfg_out_base(cfg_out),
      .busy(busy), .DEBUG_state(dbg_state)
   );

   // BRAM: address register plus output register, two cycles from request to data
   logic [31:0] mem [0:63];
   logic [31:0] addr_q = '0;
   logic        en_q = 1'b0;
   always @(posedge clk) begin
      if (en_q) data_out <= mem[addr_q[7:2]];
      addr_q <= addr;
      en_q   <= enable;
      if (enable && we == 4'hF) mem[addr[7:2]] = din;
   end

   int          checks = 0;
   int          errors = 0;
   int          starts = 0;
   int          cyc = 0;
   logic [63:0] wlog [$];
   int          reads0 [$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (array_start) starts++;
      if (enable && we != 4'h0) wlog.push_back({addr, din});
      if (enable && we == 4'h0 && addr == 32'd0) reads0.push_back(cyc);
      checks++;
      if (!(we == 4'h0 || we == 4'hF) || (we == 4'h0 && din != 0) || (!rst_n && we != 4'h0)) begin
         errors++;
         $display("FAIL bus_rules: we=%h din=0x%08h rst_n=%b required we in {0,F}, din=0 without write, no write in reset",
                  we, din, rst_n);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Job-level view of STATUS: what the host should read back for a descriptor and done time
   function automatic logic [31:0] model_status(input logic [31:0] len, input int done_at);
      if (len == 32'd0) return 32'h0000_0001;
      if (done_at > 0 && done_at <= T) return (32'(done_at) << 8) | 32'h1;
      return (32'(T) << 8) | 32'h2;
   endfunction

   // done_at: RUN cycle (1-based) in which array_done is high for one cycle; 0 = never
   task automatic run_job(input logic [31:0] len, input logic [31:0] act, input logic [31:0] wgt,
                          input logic [31:0] ob, input int done_at, input logic [31:0] exp_status,
                          input bit arm, input string tag);
      int          since;
      bit          fin;
      logic [31:0] r;
      if (arm) begin
         mem[1] = len; mem[2] = act; mem[3] = wgt; mem[4] = ob; mem[5] = '0;
      end
      wlog.delete();
      starts = 0;
      if (arm) begin
         r = $urandom();
         mem[0] = r | 32'h1;
      end
      since = 0;
      fin   = 1'b0;
      for (int k = 0; k < 400 && !(fin && (since == 0 || since > done_at)); k++) begin
         @(posedge clk); #1;
         array_done = 1'b0;
         if (since > 0) since++;
         else if (starts > 0) since = 1;
         if (since > 0 && since == done_at) array_done = 1'b1;
         if (wlog.size() >= 2) fin = 1'b1;
      end
      array_done = 1'b0;
      chk($sformatf("%s completed", tag), 64'(fin), 64'd1);
      chk($sformatf("%s write_count", tag), 64'(wlog.size()), 64'd2);
      chk($sformatf("%s status_write", tag), (wlog.size() > 0) ? wlog[0] : 64'd0, {32'd20, exp_status});
      chk($sformatf("%s cmd_clear_write", tag), (wlog.size() > 1) ? wlog[1] : 64'hDEAD, 64'd0);
      chk($sformatf("%s mem_status", tag), 64'(mem[5]), 64'(exp_status));
      chk($sformatf("%s mem_cmd", tag), 64'(mem[0]), 64'd0);
      chk($sformatf("%s start_pulses", tag), 64'(starts), (len != 0) ? 64'd1 : 64'd0);
      chk($sformatf("%s cfg_len_act", tag), {cfg_len, cfg_act}, {len, act});
      chk($sformatf("%s cfg_wgt_out", tag), {cfg_wgt, cfg_out}, {wgt, ob});
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s busy_after", tag), 64'(busy), 64'd0);
      $display("job %-8s len=%0d done_at=%0d status=0x%08h starts=%0d", tag, len, done_at, mem[5], starts);
   endtask

   typedef struct {
      logic [31:0] len;
      logic [31:0] act;
      logic [31:0] wgt;
      logic [31:0] ob;
      int          done_at;
      logic [31:0] exp_status;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [31:0] r;
      logic [31:0] len;
      int          d;
      bit          seen;

      vecs[0] = '{32'd4, 32'h100, 32'h200, 32'h300, 50, 32'h0000_3201};
      vecs[1] = '{32'd0, 32'h00A, 32'h00B, 32'h00C, 5,  32'h0000_0001};
      vecs[2] = '{32'd9, 32'h1000, 32'h2000, 32'h3000, 0, 32'h0000_4002};
      vecs[3] = '{32'd2, 32'h40, 32'h80, 32'hC0, 64, 32'h0000_4001};
      vecs[4] = '{32'd1, 32'h4, 32'h8, 32'hC, 1, 32'h0000_0101};
      vecs[5] = '{32'd7, 32'h70, 32'h71, 32'h72, 67, 32'h0000_4002};
      vecs[6] = '{32'd3, 32'h30, 32'h31, 32'h32, 63, 32'h0000_3F01};

      for (int i = 0; i < 64; i++) mem[i] = '0;
      r = $urandom();
      mem[0] = r & 32'hFFFF_FFFE;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_bus", {addr, din}, 64'd0);
      chk("reset_ctrl", {enable, we, array_start, busy, dbg_state}, 64'd0);
      chk("reset_cfg_a", {cfg_len, cfg_act}, 64'd0);
      chk("reset_cfg_b", {cfg_wgt, cfg_out}, 64'd0);

      // Idle polling with CMD bit0 clear (upper bits random)
      @(posedge clk); #1;
      rst_n = 1'b1;
      reads0.delete(); wlog.delete(); starts = 0;
      repeat (100) @(posedge clk);
      #1;
      chk("poll_read_count", 64'(reads0.size() >= 5), 64'd1);
      for (int i = 1; i < reads0.size(); i++)
         chk("poll_period", 64'(reads0[i] - reads0[i-1]), 64'(P + RDL + 1));
      chk("idle_no_writes", 64'(wlog.size()), 64'd0);
      chk("idle_no_start", 64'(starts), 64'd0);
      $display("idle: %0d CMD polls in 100 cycles", reads0.size());

      for (int i = 0; i < 7; i++)
         run_job(vecs[i].len, vecs[i].act, vecs[i].wgt, vecs[i].ob, vecs[i].done_at,
                 vecs[i].exp_status, 1'b1, $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         len = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
         d   = $urandom_range(0, 80);
         run_job(len, $urandom(), $urandom(), $urandom(), d, model_status(len, d), 1'b1,
                 $sformatf("rnd%0d", i));
      end

      // Reset pulled mid-RUN: outputs drop at once, STATUS untouched, job reruns after release
      mem[1] = 32'd5; mem[2] = 32'h11; mem[3] = 32'h22; mem[4] = 32'h33; mem[5] = '0;
      wlog.delete(); starts = 0;
      mem[0] = 32'h1;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge clk); #1;
         if (starts > 0) seen = 1'b1;
      end
      chk("rst_test launched", 64'(seen), 64'd1);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrun_reset_bus", {addr, din}, 64'd0);
      chk("midrun_reset_ctrl", {enable, we, array_start, busy, dbg_state}, 64'd0);
      chk("midrun_reset_cfg", {cfg_len, cfg_out}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrun_no_status_write", 64'(wlog.size()), 64'd0);
      chk("midrun_status_untouched", 64'(mem[5]), 64'd0);
      chk("midrun_cmd_still_set", 64'(mem[0][0]), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_job(32'd5, 32'h11, 32'h22, 32'h33, 20, 32'h0000_1401, 1'b0, "rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at 5 ms, required to finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
